// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the RegisterFile write port, plus a
// 32-entry pending-write scoreboard answering hazard queries for two sources.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              alloc_valid,
    input  logic [4:0]        alloc_rd,

    input  logic              wb0_valid,
    input  logic [4:0]        wb0_rd,
    input  logic [DATA_W-1:0] wb0_wd,
    output logic              wb0_ready,

    input  logic              wb1_valid,
    input  logic [4:0]        wb1_rd,
    input  logic [DATA_W-1:0] wb1_wd,
    output logic              wb1_ready,

    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_wd,

    input  logic [4:0]        qry_rs1,
    input  logic [4:0]        qry_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [5:0]        pending_cnt
);

    // r_ptr == 0 favours requester 0 when both are valid
    logic              r_ptr;
    logic [31:0]       r_busy;
    logic              r_rf_we;
    logic [4:0]        r_rf_rd;
    logic [DATA_W-1:0] r_rf_wd;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_wd;
    logic [31:0]       w_set;
    logic [31:0]       w_clr;
    logic [31:0]       w_busy_nxt;
    logic [5:0]        w_cnt;

    assign w_gnt0 = !rst && wb0_valid && (!wb1_valid || !r_ptr);
    assign w_gnt1 = !rst && wb1_valid && (!wb0_valid ||  r_ptr);
    assign w_xfer = w_gnt0 || w_gnt1;
    assign w_rd   = w_gnt1 ? wb1_rd : wb0_rd;
    assign w_wd   = w_gnt1 ? wb1_wd : wb0_wd;

    assign wb0_ready = w_gnt0;
    assign wb1_ready = w_gnt1;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (alloc_valid)
            w_set[alloc_rd] = 1'b1;
        if (w_xfer)
            w_clr[w_rd] = 1'b1;
        // set after clear so a new producer on the same index wins; x0 never busy
        w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < 32; i++)
            w_cnt = w_cnt + 6'(r_busy[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= 1'b0;
            r_busy  <= '0;
            r_rf_we <= 1'b0;
            r_rf_rd <= '0;
            r_rf_wd <= '0;
        end else begin
            if (w_xfer)
                r_ptr <= w_gnt0;
            r_busy  <= w_busy_nxt;
            r_rf_we <= w_xfer && (w_rd != 5'd0);
            if (w_xfer && (w_rd != 5'd0)) begin
                r_rf_rd <= w_rd;
                r_rf_wd <= w_wd;
            end
        end
    end

    assign rf_we       = r_rf_we;
    assign rf_rd       = r_rf_rd;
    assign rf_wd       = r_rf_wd;
    assign rs1_busy    = r_busy[qry_rs1];
    assign rs2_busy    = r_busy[qry_rs2];
    assign pending_cnt = w_cnt;

endmodule
